// File: rtl/cxu_mac_pipe_pkg.sv
// Shared definitions for the pipelined multiply/accumulate CXU.
package cxu_mac_pkg;

    localparam logic [2:0] FN_MUL    = 3'd0;
    localparam logic [2:0] FN_MULH   = 3'd1;
    localparam logic [2:0] FN_MULHU  = 3'd2;
    localparam logic [2:0] FN_MAC    = 3'd3;
    localparam logic [2:0] FN_ACCLO  = 3'd4;
    localparam logic [2:0] FN_ACCHI  = 3'd5;
    localparam logic [2:0] FN_ACCCLR = 3'd6;
    localparam logic [2:0] FN_RSVD   = 3'd7;

    // One pipeline slot: the product travels separately in the multiplier.
    typedef struct packed {
        logic       valid;
        logic [2:0] fn;
        logic [2:0] sid;
    } slot_t;

    localparam slot_t SLOT_IDLE = '{valid: 1'b0, fn: FN_MUL, sid: 3'd0};

    // Only the unsigned high-word multiply zero-extends its operands.
    function automatic logic sign_ext_fn(input logic [2:0] fn);
        return (fn != FN_MULHU);
    endfunction

endpackage

// File: rtl/cxu_mac_pipe_if.sv
// Custom-instruction bus between CPU (master) and CXU (slave).
interface cxu_mac_pipe_if #(parameter int XLEN = 32);

    logic            cmd_valid;
    logic            cmd_ready;
    logic [2:0]      cmd_payload_function_id;
    logic [XLEN-1:0] cmd_payload_inputs_0;
    logic [XLEN-1:0] cmd_payload_inputs_1;
    logic [2:0]      cmd_payload_state_id;
    logic [3:0]      cmd_payload_cxu_id;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_payload_outputs_0;

    modport master (
        output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, cmd_payload_state_id, cmd_payload_cxu_id, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

    modport slave (
        input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
               cmd_payload_inputs_1, cmd_payload_state_id, cmd_payload_cxu_id, rsp_ready,
        output cmd_ready, rsp_valid, rsp_payload_outputs_0
    );

endinterface

// File: rtl/cxu_mac_pipe_mul.sv
// (XLEN+1)x(XLEN+1) signed multiplier: operands captured alongside slot 0,
// product delayed so it lines up with the last slot.
module cxu_mul_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic signed [XLEN:0]   a,
    input  logic signed [XLEN:0]   b,
    output logic signed [2*XLEN+1:0] product
);

    localparam int PW = 2 * XLEN + 2;

    logic signed [XLEN:0] a_r;
    logic signed [XLEN:0] b_r;
    logic signed [PW-1:0] prod_s;

    // Operand capture in step with the slot-0 load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r <= {(XLEN+1){1'b0}};
            b_r <= {(XLEN+1){1'b0}};
        end else if (en) begin
            a_r <= a;
            b_r <= b;
        end
    end

    assign prod_s = PW'(a_r) * PW'(b_r);

    generate
        if (STAGES == 1) begin : g_comb
            assign product = prod_s;
        end else begin : g_pipe
            logic signed [PW-1:0] stage_r [STAGES-1];

            // Product delay line; holds with the rest of the pipeline.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < STAGES - 1; i++) begin
                        stage_r[i] <= {PW{1'b0}};
                    end
                end else if (en) begin
                    stage_r[0] <= prod_s;
                    for (int i = 1; i < STAGES - 1; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign product = stage_r[STAGES-2];
        end
    endgenerate

endmodule

// File: rtl/cxu_mac_pipe.sv
// Pipelined multiply / multiply-accumulate CXU with NUM_ACC accumulators.
// Accumulators are read and written only on the final transfer into the
// output register, so consecutive ops on one sid need no forwarding.
module cxu_mac_pipe import cxu_mac_pkg::*; #(
    parameter int XLEN    = 32,
    parameter int STAGES  = 2,
    parameter int NUM_ACC = 8,
    parameter int ACC_W   = 64
) (
    input  logic          clk,
    input  logic          reset,
    cxu_mac_pipe_if.slave bus
);

    logic                      en_s;
    slot_t                     slot_r [STAGES];
    slot_t                     last_s;
    logic signed [XLEN:0]      a_ext_s;
    logic signed [XLEN:0]      b_ext_s;
    logic signed [2*XLEN+1:0]  prod_s;
    logic signed [2*XLEN-1:0]  prod_w_s;
    logic [ACC_W-1:0]          acc_r [NUM_ACC];
    logic [ACC_W-1:0]          acc_old_s;
    logic [ACC_W-1:0]          acc_add_s;
    logic [ACC_W-1:0]          mac_sum_s;
    logic [ACC_W-1:0]          acc_wdata_s;
    logic                      acc_we_s;
    logic                      sid_ok_s;
    logic [XLEN-1:0]           result_s;
    logic                      rsp_valid_r;
    logic [XLEN-1:0]           rsp_data_r;
    logic                      unused_bits_s;

    assign en_s                      = !(rsp_valid_r && !bus.rsp_ready);
    assign bus.cmd_ready             = en_s;
    assign bus.rsp_valid             = rsp_valid_r;
    assign bus.rsp_payload_outputs_0 = rsp_data_r;
    assign last_s                    = slot_r[STAGES-1];
    assign unused_bits_s             = ^{bus.cmd_payload_cxu_id, prod_s[2*XLEN+1:2*XLEN]};

    // Operand extension: zero for the unsigned high multiply, signed otherwise.
    always_comb begin
        if (sign_ext_fn(bus.cmd_payload_function_id)) begin
            a_ext_s = {bus.cmd_payload_inputs_0[XLEN-1], bus.cmd_payload_inputs_0};
            b_ext_s = {bus.cmd_payload_inputs_1[XLEN-1], bus.cmd_payload_inputs_1};
        end else begin
            a_ext_s = {1'b0, bus.cmd_payload_inputs_0};
            b_ext_s = {1'b0, bus.cmd_payload_inputs_1};
        end
    end

    cxu_mul_pipe #(.XLEN(XLEN), .STAGES(STAGES)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .en      (en_s),
        .a       (a_ext_s),
        .b       (b_ext_s),
        .product (prod_s)
    );

    // Slot shift register; bubbles enter as valid=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < STAGES; i++) begin
                slot_r[i] <= SLOT_IDLE;
            end
        end else if (en_s) begin
            slot_r[0] <= '{valid: bus.cmd_valid,
                           fn:    bus.cmd_payload_function_id,
                           sid:   bus.cmd_payload_state_id};
            for (int i = 1; i < STAGES; i++) begin
                slot_r[i] <= slot_r[i-1];
            end
        end
    end

    // Accumulator select and result muxing for the op leaving the last slot.
    always_comb begin
        sid_ok_s  = ({1'b0, last_s.sid} < 4'(NUM_ACC));
        prod_w_s  = prod_s[2*XLEN-1:0];
        acc_add_s = ACC_W'(prod_w_s);
        acc_old_s = {ACC_W{1'b0}};
        for (int i = 0; i < NUM_ACC; i++) begin
            acc_old_s = (last_s.sid == 3'(i)) ? acc_r[i] : acc_old_s;
        end
        mac_sum_s   = acc_old_s + acc_add_s;
        result_s    = {XLEN{1'b0}};
        acc_we_s    = 1'b0;
        acc_wdata_s = {ACC_W{1'b0}};
        case (last_s.fn)
            FN_MUL:   result_s = prod_s[XLEN-1:0];
            FN_MULH:  result_s = prod_s[2*XLEN-1:XLEN];
            FN_MULHU: result_s = prod_s[2*XLEN-1:XLEN];
            FN_MAC: begin
                if (sid_ok_s) begin
                    acc_we_s    = 1'b1;
                    acc_wdata_s = mac_sum_s;
                    result_s    = mac_sum_s[XLEN-1:0];
                end else begin
                    result_s = {XLEN{1'b0}};
                end
            end
            FN_ACCLO: begin
                if (sid_ok_s) result_s = acc_old_s[XLEN-1:0];
                else          result_s = {XLEN{1'b0}};
            end
            FN_ACCHI: begin
                if (sid_ok_s) result_s = acc_old_s[2*XLEN-1:XLEN];
                else          result_s = {XLEN{1'b0}};
            end
            FN_ACCCLR: begin
                if (sid_ok_s) begin
                    acc_we_s    = 1'b1;
                    acc_wdata_s = {ACC_W{1'b0}};
                    result_s    = acc_old_s[XLEN-1:0];
                end else begin
                    result_s = {XLEN{1'b0}};
                end
            end
            default:  result_s = {XLEN{1'b0}};
        endcase
    end

    // Accumulator write-back, only when a valid op moves into the output register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                acc_r[i] <= {ACC_W{1'b0}};
            end
        end else if (en_s && last_s.valid && acc_we_s) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                if (last_s.sid == 3'(i)) begin
                    acc_r[i] <= acc_wdata_s;
                end
            end
        end
    end

    // Output register; data is held until the CPU takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {XLEN{1'b0}};
        end else if (en_s) begin
            rsp_valid_r <= last_s.valid;
            if (last_s.valid) begin
                rsp_data_r <= result_s;
            end
        end
    end

endmodule

// File: tb/tb_cxu_mac_pipe.sv
// Self-checking bench for cxu_mac_pipe with a 64-bit arithmetic reference model.
module tb_cxu_mac_pipe;
    import cxu_mac_pkg::*;

    localparam int XLEN    = 32;
    localparam int STAGES  = 2;
    localparam int NUM_ACC = 4;
    localparam int ACC_W   = 64;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cxu_mac_pipe_if #(.XLEN(XLEN)) bus ();

    cxu_mac_pipe #(.XLEN(XLEN), .STAGES(STAGES), .NUM_ACC(NUM_ACC), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic [63:0] macc [8];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every response the CPU side takes (transfer happens at the next rising edge).
    always @(negedge clk) begin
        if (reset && bus.rsp_valid && bus.rsp_ready) got_q.push_back(bus.rsp_payload_outputs_0);
    end

    function automatic logic [31:0] model(input logic [2:0] fn, input logic [31:0] a,
                                          input logic [31:0] b, input logic [2:0] sid);
        longint      sa, sb, sp;
        logic [63:0] up, pb, old;
        logic        ok;
        logic [31:0] r;
        sa  = $signed(a);
        sb  = $signed(b);
        sp  = sa * sb;
        up  = {32'd0, a} * {32'd0, b};
        ok  = (int'(sid) < NUM_ACC);
        old = ok ? macc[sid] : 64'd0;
        pb  = sp;
        r   = 32'd0;
        case (fn)
            FN_MUL:    r = pb[31:0];
            FN_MULH:   r = pb[63:32];
            FN_MULHU:  r = up[63:32];
            FN_MAC:    if (ok) begin macc[sid] = old + pb; r = macc[sid][31:0]; end
            FN_ACCLO:  if (ok) r = old[31:0];
            FN_ACCHI:  if (ok) r = old[63:32];
            FN_ACCCLR: if (ok) begin r = old[31:0]; macc[sid] = 64'd0; end
            default:   r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic issue(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] sid);
        bit ok = 1'b0;
        bus.cmd_valid               = 1'b1;
        bus.cmd_payload_function_id = fn;
        bus.cmd_payload_inputs_0    = a;
        bus.cmd_payload_inputs_1    = b;
        bus.cmd_payload_state_id    = sid;
        bus.cmd_payload_cxu_id      = 4'($urandom);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.cmd_ready;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL issue_timeout cmd_ready stayed 0 fn %0d", fn);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (ok) exp_q.push_back(model(fn, a, b, sid));
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.rsp_ready = 1'b1;
        while (got_q.size() < exp_q.size() && n < 200) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count got %0d responses, expected %0d", name, got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.rsp_valid); end
        checks++;
        if (bus.rsp_payload_outputs_0 !== 32'd0) begin
            errors++; $display("FAIL reset_data got %h exp 00000000", bus.rsp_payload_outputs_0);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus.cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_mul_latency();
        int acc_c, n;
        logic [31:0] e, g;
        issue(FN_MUL, 32'hFFFF_FFFD, 32'd7, 3'd0);
        acc_c = cyc;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (cyc - acc_c != STAGES) begin
            errors++; $display("FAIL mul_latency got %0d cycles exp %0d", cyc - acc_c, STAGES);
        end
        drain("mul");
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e || g !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_value got %h exp %h", g, e); end
        end
    endtask

    task automatic test_high_word();
        logic [31:0] e, g;
        issue(FN_MULH,  32'h8000_0000, 32'h8000_0000, 3'd0);
        issue(FN_MULHU, 32'hFFFF_FFFF, 32'd2, 3'd0);
        issue(FN_MULH,  32'hFFFF_FFFF, 32'd2, 3'd0);
        drain("high");
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL high_word got %h exp %h", g, e); end
        end
    endtask

    task automatic test_mac_back_to_back();
        logic [31:0] e, g;
        issue(FN_MAC,   32'd5, 32'd6, 3'd2);
        issue(FN_MAC,   32'hFFFF_FFF6, 32'd4, 3'd2);
        issue(FN_ACCHI, 32'd0, 32'd0, 3'd2);
        issue(FN_ACCLO, 32'd0, 32'd0, 3'd3);
        drain("mac");
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL mac_seq got %h exp %h", g, e); end
        end
    endtask

    task automatic test_clear_reserved_range();
        logic [31:0] e, g;
        issue(FN_ACCCLR, 32'd0, 32'd0, 3'd2);
        issue(FN_ACCLO,  32'd0, 32'd0, 3'd2);
        issue(FN_RSVD,   32'h1234_5678, 32'h9ABC_DEF0, 3'd1);
        issue(FN_MAC,    32'd123, 32'd456, 3'd5);
        issue(FN_ACCLO,  32'd0, 32'd0, 3'd5);
        for (int s = 0; s < NUM_ACC; s++) issue(FN_ACCLO, 32'd0, 32'd0, 3'(s));
        drain("misc");
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL clear_rsvd_range got %h exp %h", g, e); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] e, g;
        bus.rsp_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 4; i++) issue(FN_MUL, 32'(i), 32'd1, 3'd0);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                checks++;
                if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b exp 0", bus.cmd_ready); end
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_payload_outputs_0 !== 32'd1) begin
                    errors++; $display("FAIL bp_hold1 got v=%b d=%h exp v=1 d=00000001",
                                       bus.rsp_valid, bus.rsp_payload_outputs_0);
                end
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_payload_outputs_0 !== 32'd1) begin
                    errors++; $display("FAIL bp_hold2 got v=%b d=%h exp v=1 d=00000001",
                                       bus.rsp_valid, bus.rsp_payload_outputs_0);
                end
                @(posedge clk); #1;
                bus.rsp_ready = 1'b1;
            end
        join
        drain("bp");
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL bp_order got %h exp %h", g, e); end
        end
    endtask

    task automatic test_random();
        logic [31:0] e, g, a, b;
        bit done = 1'b0;
        fork
            begin
                for (int n = 0; n < 80; n++) begin
                    a = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
                    b = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                    if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
                    issue(3'($urandom_range(0, 7)), a, b, 3'($urandom_range(0, 7)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain("rand");
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL random got %h exp %h", g, e); end
        end
    endtask

    task automatic test_reset_in_flight();
        logic [31:0] e, g;
        bus.rsp_ready = 1'b0;
        issue(FN_MAC, 32'd1000, 32'd3, 3'd1);
        issue(FN_MAC, 32'd7, 32'd7, 3'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_payload_outputs_0 !== 32'd0) begin
            errors++; $display("FAIL async_reset got v=%b d=%h exp v=0 d=00000000",
                               bus.rsp_valid, bus.rsp_payload_outputs_0);
        end
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < 8; i++) macc[i] = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 0 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_discard got %0d responses v=%b exp 0 v=0", got_q.size(), bus.rsp_valid);
        end
        for (int s = 0; s < 8; s++) issue(FN_ACCLO, $urandom, $urandom, 3'(s));
        drain("post_reset");
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g !== e || g !== 32'd0) begin errors++; $display("FAIL post_reset_acc got %h exp %h", g, e); end
        end
    endtask

    initial begin
        bus.cmd_valid               = 1'b0;
        bus.cmd_payload_function_id = 3'd0;
        bus.cmd_payload_inputs_0    = 32'd0;
        bus.cmd_payload_inputs_1    = 32'd0;
        bus.cmd_payload_state_id    = 3'd0;
        bus.cmd_payload_cxu_id      = 4'd0;
        bus.rsp_ready               = 1'b1;
        for (int i = 0; i < 8; i++) macc[i] = 64'd0;
        test_reset();
        test_mul_latency();
        test_high_word();
        test_mac_back_to_back();
        test_clear_reserved_range();
        test_backpressure();
        test_random();
        test_reset_in_flight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
